// File: rtl/keypad_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | keypad_scanner: 4x3 matrix scan, sweep-level debounce, key-press strobe.  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module keypad_scanner #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] Row,
  output logic [2:0] Col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  localparam logic [DIV_W-1:0] c_dwell_last = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] c_dwell_one  = DIV_W'(1);
  localparam logic [CNT_W-1:0] c_stab_max   = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] c_stab_one   = CNT_W'(1);

  // Candidate encoding: 0 = none, k+1 = single key k, 13 = several keys.
  localparam logic [3:0] c_cand_none  = 4'd0;
  localparam logic [3:0] c_cand_multi = 4'd13;

  localparam logic [0:0] c_st_released = 1'b0;
  localparam logic [0:0] c_st_held     = 1'b1;

  logic [DIV_W-1:0] dwell_q, dwell_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [2:0]       col_q, col_d;
  logic [11:0]      snap_q, snap_d;
  logic [3:0]       cand_prev_q, cand_prev_d;
  logic [CNT_W-1:0] stab_q, stab_d;
  logic [0:0]       state_q, state_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;

  logic        w_sample;
  logic        w_sweep_done;
  logic [11:0] w_snap_full;
  logic [3:0]  w_cand;
  logic        w_is_key;
  logic        w_eval;
  logic [3:0]  w_ones;
  logic [3:0]  w_idx;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dwell_q     <= '0;
      col_idx_q   <= 2'd0;
      col_q       <= 3'b001;
      snap_q      <= '0;
      cand_prev_q <= c_cand_none;
      stab_q      <= '0;
      state_q     <= c_st_released;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      dwell_q     <= dwell_d;
      col_idx_q   <= col_idx_d;
      col_q       <= col_d;
      snap_q      <= snap_d;
      cand_prev_q <= cand_prev_d;
      stab_q      <= stab_d;
      state_q     <= state_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  // Column sequencing and snapshot; the live Row sample is merged in so the
  // sweep-completing edge sees the full 12-bit picture.
  always_comb begin
    w_sample     = (dwell_q == c_dwell_last);
    w_sweep_done = w_sample && (col_idx_q == 2'd2);
    w_snap_full  = snap_q;
    if (w_sample) begin
      case (col_idx_q)
        2'd0:    for (int r = 0; r < 4; r++) w_snap_full[3*r]     = Row[r];
        2'd1:    for (int r = 0; r < 4; r++) w_snap_full[3*r + 1] = Row[r];
        default: for (int r = 0; r < 4; r++) w_snap_full[3*r + 2] = Row[r];
      endcase
    end
    snap_d    = w_snap_full;
    dwell_d   = w_sample ? '0 : dwell_q + c_dwell_one;
    col_idx_d = col_idx_q;
    col_d     = col_q;
    if (w_sample) begin
      col_idx_d = (col_idx_q == 2'd2) ? 2'd0 : col_idx_q + 2'd1;
      col_d     = {col_q[1:0], col_q[2]};
    end
  end

  always_comb begin
    w_ones = 4'd0;
    w_idx  = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (w_snap_full[i]) begin
        w_ones = w_ones + 4'd1;
        w_idx  = 4'(i);
      end
    end
    if (w_ones == 4'd0)      w_cand = c_cand_none;
    else if (w_ones == 4'd1) w_cand = w_idx + 4'd1;
    else                     w_cand = c_cand_multi;
    w_is_key = (w_cand != c_cand_none) && (w_cand != c_cand_multi);

    cand_prev_d = cand_prev_q;
    stab_d      = stab_q;
    if (w_sweep_done) begin
      if (w_cand == cand_prev_q)
        stab_d = (stab_q == c_stab_max) ? stab_q : stab_q + c_stab_one;
      else
        stab_d = c_stab_one;
      cand_prev_d = w_cand;
    end
    w_eval = w_sweep_done && (stab_d == c_stab_max);
  end

  always_comb begin
    state_d = state_q;
    if (w_eval) begin
      case (state_q)
        c_st_released: if (w_is_key) state_d = c_st_held;
        default:       if (!w_is_key) state_d = c_st_released;
      endcase
    end
  end

  // key_code_q doubles as the identity of the held key.
  always_comb begin
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    key_held_d  = (state_d == c_st_held);
    if (w_eval && w_is_key &&
        ((state_q == c_st_released) || ((w_cand - 4'd1) != key_code_q))) begin
      key_code_d  = w_cand - 4'd1;
      key_valid_d = 1'b1;
    end
  end

  assign Col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_keypad_scanner: scoreboard bench for keypad_scanner with a row model.  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_keypad_scanner;

  typedef struct {
    int         cyc;
    logic [3:0] code;
  } ev_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] key   = '0;
  logic [3:0]  row;
  logic [2:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  int   cyc;
  int   n_cmp = 0;
  int   n_err = 0;
  int   rd    = 0;
  ev_t  exp_q[$];
  ev_t  obs_q[$];
  ev_t  mon_ev;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .Row       (row),
    .Col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clock = ~clock;

  always_comb begin
    row = '0;
    for (int r = 0; r < 4; r++) row[r] = |(key[3*r +: 3] & col);
  end

  // cyc = number of rising edges since reset deassertion.
  always @(posedge clock or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clock) begin
    if (reset && key_valid) begin
      mon_ev.cyc  = cyc;
      mon_ev.code = key_code;
      obs_q.push_back(mon_ev);
    end
  end

  task automatic do_reset();
    @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    #2 reset = 1'b1;
  endtask

  task automatic to_cycle(input int n);
    while (cyc < n) @(negedge clock);
  endtask

  task automatic push_exp(input int c, input logic [3:0] code);
    ev_t e;
    e.cyc  = c;
    e.code = code;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    logic [2:0] exp_col;
    key = '0;
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (col !== 3'b001) begin n_err++; $display("FAIL rst_col: got %b want 001", col); end
    n_cmp++; if (key_code !== 4'd0) begin n_err++; $display("FAIL rst_code: got %0d want 0", key_code); end
    n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", key_valid); end
    n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL rst_held: got %b want 0", key_held); end
    @(negedge clock);
    #2 reset = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      to_cycle(k);
      exp_col = 3'b001 << ((k / 4) % 3);
      n_cmp++; if (col !== exp_col) begin n_err++; $display("FAIL scan_col c%0d: got %b want %b", k, col, exp_col); end
      n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL idle_held c%0d: got %b want 0", k, key_held); end
    end
    n_cmp++; if (obs_q.size() != rd) begin n_err++; $display("FAIL idle_pulses: got %0d want 0", obs_q.size() - rd); rd = obs_q.size(); end
  endtask

  task automatic test_single_press();
    ev_t e;
    key = 12'd1 << 5;
    do_reset();
    push_exp(36, 4'd5);
    to_cycle(35);
    n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL press_held_early: got %b want 0", key_held); end
    for (int k = 36; k <= 72; k++) begin
      to_cycle(k);
      n_cmp++; if (key_held !== 1'b1) begin n_err++; $display("FAIL press_held c%0d: got %b want 1", k, key_held); end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (rd >= obs_q.size()) begin n_err++; $display("FAIL press_pulse: got none want code %0d at c%0d", e.code, e.cyc); end
      else begin
        if (obs_q[rd].cyc !== e.cyc || obs_q[rd].code !== e.code) begin
          n_err++; $display("FAIL press_pulse: got code %0d at c%0d want code %0d at c%0d", obs_q[rd].code, obs_q[rd].cyc, e.code, e.cyc);
        end
        rd++;
      end
    end
    n_cmp++; if (obs_q.size() != rd) begin n_err++; $display("FAIL press_extra: got %0d extra pulses want 0", obs_q.size() - rd); rd = obs_q.size(); end
  endtask

  task automatic test_bounce();
    ev_t e;
    key = '0;
    do_reset();
    for (int s = 0; s < 4; s++) begin
      key = (s % 2 == 0) ? (12'd1 << 7) : 12'd0;
      to_cycle(12 * (s + 1));
    end
    key = 12'd1 << 7;
    push_exp(84, 4'd7);
    to_cycle(83);
    n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL bounce_held_early: got %b want 0", key_held); end
    to_cycle(84);
    n_cmp++; if (key_held !== 1'b1) begin n_err++; $display("FAIL bounce_held: got %b want 1", key_held); end
    to_cycle(108);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (rd >= obs_q.size()) begin n_err++; $display("FAIL bounce_pulse: got none want code %0d at c%0d", e.code, e.cyc); end
      else begin
        if (obs_q[rd].cyc !== e.cyc || obs_q[rd].code !== e.code) begin
          n_err++; $display("FAIL bounce_pulse: got code %0d at c%0d want code %0d at c%0d", obs_q[rd].code, obs_q[rd].cyc, e.code, e.cyc);
        end
        rd++;
      end
    end
    n_cmp++; if (obs_q.size() != rd) begin n_err++; $display("FAIL bounce_extra: got %0d extra pulses want 0", obs_q.size() - rd); rd = obs_q.size(); end
  endtask

  task automatic test_release_repress();
    ev_t e;
    key = 12'd1;
    do_reset();
    push_exp(36, 4'd0);
    to_cycle(48);
    key = '0;
    to_cycle(83);
    n_cmp++; if (key_held !== 1'b1) begin n_err++; $display("FAIL release_held_early: got %b want 1", key_held); end
    to_cycle(84);
    n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL release_held: got %b want 0", key_held); end
    n_cmp++; if (key_code !== 4'd0) begin n_err++; $display("FAIL release_code: got %0d want 0", key_code); end
    to_cycle(96);
    key = 12'd1;
    push_exp(132, 4'd0);
    to_cycle(144);
    n_cmp++; if (key_held !== 1'b1) begin n_err++; $display("FAIL repress_held: got %b want 1", key_held); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (rd >= obs_q.size()) begin n_err++; $display("FAIL release_pulse: got none want code %0d at c%0d", e.code, e.cyc); end
      else begin
        if (obs_q[rd].cyc !== e.cyc || obs_q[rd].code !== e.code) begin
          n_err++; $display("FAIL release_pulse: got code %0d at c%0d want code %0d at c%0d", obs_q[rd].code, obs_q[rd].cyc, e.code, e.cyc);
        end
        rd++;
      end
    end
    n_cmp++; if (obs_q.size() != rd) begin n_err++; $display("FAIL release_extra: got %0d extra pulses want 0", obs_q.size() - rd); rd = obs_q.size(); end
  endtask

  task automatic test_multi_and_change();
    ev_t e;
    key = (12'd1 << 1) | (12'd1 << 11);
    do_reset();
    to_cycle(72);
    n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL multi_held: got %b want 0", key_held); end
    n_cmp++; if (obs_q.size() != rd) begin n_err++; $display("FAIL multi_pulse: got %0d pulses want 0", obs_q.size() - rd); rd = obs_q.size(); end
    key = 12'd1 << 2;
    do_reset();
    push_exp(36, 4'd2);
    to_cycle(48);
    key = 12'd1 << 9;
    push_exp(84, 4'd9);
    for (int k = 36; k <= 96; k++) begin
      to_cycle(k);
      n_cmp++; if (key_held !== 1'b1) begin n_err++; $display("FAIL change_held c%0d: got %b want 1", k, key_held); end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (rd >= obs_q.size()) begin n_err++; $display("FAIL change_pulse: got none want code %0d at c%0d", e.code, e.cyc); end
      else begin
        if (obs_q[rd].cyc !== e.cyc || obs_q[rd].code !== e.code) begin
          n_err++; $display("FAIL change_pulse: got code %0d at c%0d want code %0d at c%0d", obs_q[rd].code, obs_q[rd].cyc, e.code, e.cyc);
        end
        rd++;
      end
    end
    n_cmp++; if (obs_q.size() != rd) begin n_err++; $display("FAIL change_extra: got %0d extra pulses want 0", obs_q.size() - rd); rd = obs_q.size(); end
  endtask

  task automatic test_reset_mid_debounce();
    ev_t e;
    key = 12'd1 << 4;
    do_reset();
    to_cycle(30);
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (col !== 3'b001) begin n_err++; $display("FAIL mid_rst_col: got %b want 001", col); end
    n_cmp++; if (key_code !== 4'd0) begin n_err++; $display("FAIL mid_rst_code: got %0d want 0", key_code); end
    n_cmp++; if (key_valid !== 1'b0 || key_held !== 1'b0) begin
      n_err++; $display("FAIL mid_rst_flags: got valid=%b held=%b want 0 0", key_valid, key_held);
    end
    @(negedge clock);
    #2 reset = 1'b1;
    push_exp(36, 4'd4);
    to_cycle(35);
    n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL mid_held_early: got %b want 0", key_held); end
    to_cycle(48);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (rd >= obs_q.size()) begin n_err++; $display("FAIL mid_pulse: got none want code %0d at c%0d", e.code, e.cyc); end
      else begin
        if (obs_q[rd].cyc !== e.cyc || obs_q[rd].code !== e.code) begin
          n_err++; $display("FAIL mid_pulse: got code %0d at c%0d want code %0d at c%0d", obs_q[rd].code, obs_q[rd].cyc, e.code, e.cyc);
        end
        rd++;
      end
    end
    n_cmp++; if (obs_q.size() != rd) begin n_err++; $display("FAIL mid_extra: got %0d extra pulses want 0", obs_q.size() - rd); rd = obs_q.size(); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_release_repress();
    test_multi_and_change();
    test_reset_mid_debounce();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
